memory_block_mover: RTL and testbench
=====================================

// Module: memory_block_mover
// PURPOSE
//  Write-side initiator for the single-port-read / negedge-write RAM: on a start pulse it
//  copies a block of words between two RAM regions (memmove semantics) or fills a region
//  with a constant. It drives radr/wadr/wvalue/wenable in place of the CPU while busy.
//  External arbitration (busy-based mux) lives outside this block.
// PARAMETERS
//  ADDR_WIDTH  32    width of radr/wadr/src/dst/len
//  DATA_WIDTH  32    RAM word width
//  RAM_SIZE    4096  words in the attached RAM; used for bounds checking
// PORTS
//  clock       in   1           single clock; all state updates on posedge
//  reset_n     in   1           asynchronous, active-low reset
//  start       in   1           request pulse; sampled only when idle (busy=0, done=0)
//  mode        in   1           0 = COPY, 1 = FILL; sampled with start
//  src         in   ADDR_WIDTH  source word address (COPY only); sampled with start
//  dst         in   ADDR_WIDTH  destination word address; sampled with start
//  len         in   ADDR_WIDTH  word count; sampled with start
//  fill_value  in   DATA_WIDTH  constant for FILL; sampled with start
//  busy        out  1           high while a transfer is in progress
//  done        out  1           one-cycle completion pulse
//  error       out  1           valid with done; 1 = request rejected, no writes made
//  radr        out  ADDR_WIDTH  RAM read address (registered)
//  rvalue      in   DATA_WIDTH  RAM combinational read data
//  wadr        out  ADDR_WIDTH  RAM write address (registered)
//  wvalue      out  DATA_WIDTH  RAM write data (registered)
//  wenable     out  1           RAM write enable (registered, stable across negedge)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done, error, wenable = 0; radr, wadr, wvalue = 0.
//  All outputs come from posedge flops; RAM commits on the negedge inside a wenable cycle.
//  Cycle k = period following posedge k; start accepted at posedge 0.
//  Reject: dst+len > RAM_SIZE, or COPY with src+len > RAM_SIZE (computed ADDR_WIDTH+1 wide,
//   no wrap) -> done=1, error=1 in cycle 1; busy stays 0; no writes.
//  len==0, or COPY with src==dst -> done=1, error=0 in cycle 1; no writes.
//  Direction: COPY with dst>src runs descending (word index k = len-1 .. 0), else ascending;
//   guarantees memmove-correct results for overlapping regions.
//  COPY (N=len): radr = src+idx(k) in cycle k+1, k=0..N-1; rvalue captured at posedge k+2;
//   wenable=1, wadr=dst+idx(k), wvalue=captured word in cycle k+2. One word per cycle.
//   busy=1 cycles 1..N+1; done=1 cycle N+2.
//  FILL: wenable=1, wadr=dst+idx(k), wvalue=fill_value in cycle k+1, k=0..N-1 (ascending);
//   busy=1 cycles 1..N; done=1 cycle N+1. radr held.
//  States: IDLE -> (COPY) PRIME -> STREAM -> DRAIN -> DONE -> IDLE; (FILL) FILL -> DONE;
//   (reject/empty) DONE. PRIME issues first read; STREAM overlaps read k+1 / write k;
//   DRAIN issues last write with no read; DONE asserts done for exactly one cycle.
//  start while busy or done ignored; inputs sampled only at acceptance.
//  wenable=0 in every non-writing cycle; wadr/wvalue/radr hold last value when idle.
//  Remaining-count and index counters ADDR_WIDTH wide; terminate on count reaching 0.
// STRUCTURE
//  Shared package: mode constants (MODE_COPY, MODE_FILL), state enum, RAM_SIZE default.
//  One sub-module: mover_addr_seq (base, len, descending -> per-cycle address, last flag),
//   instantiated twice (read side, write side).
// TESTING
//  Preload RAM[16..19]=A,B,C,D; COPY src=16 dst=100 len=4 -> RAM[100..103]=A..D,
//   first wenable cycle 2, done in cycle 6, busy cycles 1..5, RAM[99],[104] untouched.
//  Overlap: RAM[0..3]=1,2,3,4; COPY src=0 dst=1 len=4 -> RAM[1..4]=1,2,3,4 (descending);
//   then COPY src=1 dst=0 len=4 -> RAM[0..3]=1,2,3,4 (ascending).
//  FILL dst=200 len=3 fill=32'hDEADBEEF -> RAM[200..202]=DEADBEEF, done cycle 4, RAM[203] kept.
//  COPY dst=4094 len=4 -> done+error in cycle 1, no wenable ever; len=0 -> done, error=0.
//  Assert reset_n=0 mid-COPY (after 2 writes) -> wenable/busy drop immediately, only 2 words
//   written; start pulsed while busy -> ignored, transfer completes unchanged.

Source files
------------

// File: rtl/memory_block_mover_pkg.sv
// Shared definitions for the memory block mover.
//   MODE_COPY / MODE_FILL : values of the mode input
//   DEFAULT_RAM_SIZE      : word count of the attached RAM unless overridden
//   state_t               : controller state, also exported on dbg_state
package memory_block_mover_pkg;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int DEFAULT_RAM_SIZE = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_FILL,
    S_DONE
  } state_t;

endpackage

// File: rtl/memory_block_mover_addr_seq.sv
// mover_addr_seq: walks a block of word addresses, one per advance.
//   clock, reset_n : clock, async active-low reset
//   load           : latch base/len/descending and restart the walk
//   advance        : step to the next word (ignored once the count is exhausted)
//   base, len      : first word address of the block, word count
//   descending     : walk index len-1 .. 0 instead of 0 .. len-1
//   addr           : base + current index
//   last           : current word is the final one of the block
module mover_addr_seq #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic                  descending,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] remain_q;
  logic                  desc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      idx_q    <= '0;
      remain_q <= '0;
      desc_q   <= 1'b0;
    end else if (load) begin
      base_q   <= base;
      desc_q   <= descending;
      idx_q    <= descending ? (len - ONE) : '0;
      remain_q <= len;
    end else if (advance && (remain_q != '0)) begin
      idx_q    <= desc_q ? (idx_q - ONE) : (idx_q + ONE);
      remain_q <= remain_q - ONE;
    end
  end

  assign addr = base_q + idx_q;
  assign last = (remain_q == ONE);

endmodule

// File: rtl/memory_block_mover.sv
// memory_block_mover: copies (memmove) or fills a block of RAM words on request.
//   clock, reset_n        : clock, async active-low reset
//   start, mode           : request pulse and COPY(0)/FILL(1) select
//   src, dst, len         : source, destination and word count (sampled with start)
//   fill_value            : constant written in FILL mode (sampled with start)
//   busy, done, error     : status; done is a one-cycle pulse, error qualifies done
//   radr / rvalue         : RAM read port (registered address, combinational data)
//   wadr, wvalue, wenable : RAM write port, registered, RAM commits on negedge
//   dbg_state             : current controller state
//
// Handshake: start is taken only in a cycle where the block is idle and done is
// low; all request fields are captured on that edge and ignored afterwards. Every
// accepted request ends with exactly one done pulse, error=1 meaning it was
// rejected before any write.
module memory_block_mover
  import memory_block_mover_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = DEFAULT_RAM_SIZE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] radr,
  input  logic [DATA_WIDTH-1:0] rvalue,
  output logic [ADDR_WIDTH-1:0] wadr,
  output logic [DATA_WIDTH-1:0] wvalue,
  output logic                  wenable,
  output state_t                dbg_state
);

  // Bounds are checked one bit wider than the address so a huge len cannot wrap.
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(RAM_SIZE);

  state_t                state;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] fill_q;

  logic                  accept;
  logic                  is_copy;
  logic                  reject;
  logic                  empty;
  logic                  descending;
  logic [ADDR_WIDTH:0]   dst_end;
  logic [ADDR_WIDTH:0]   src_end;
  logic                  rd_adv;
  logic                  wr_adv;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_last;
  logic                  wr_last;

  assign accept     = (state == S_IDLE) && start && !done;
  assign is_copy    = (mode == MODE_COPY);
  assign dst_end    = {1'b0, dst} + {1'b0, len};
  assign src_end    = {1'b0, src} + {1'b0, len};
  assign reject     = (dst_end > LIMIT) || (is_copy && (src_end > LIMIT));
  assign empty      = (len == '0) || (is_copy && (src == dst));
  // Copying upward into an overlapping region must start from the top word.
  assign descending = is_copy && (dst > src);

  always_comb begin
    rd_adv = 1'b0;
    wr_adv = 1'b0;
    case (state)
      S_PRIME:  rd_adv = 1'b1;
      S_STREAM: begin
        rd_adv = 1'b1;
        wr_adv = 1'b1;
      end
      S_DRAIN:  wr_adv = 1'b1;
      S_FILL:   wr_adv = 1'b1;
      default:  ;
    endcase
  end

  mover_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_seq (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .advance    (rd_adv),
    .base       (src),
    .len        (len),
    .descending (descending),
    .addr       (rd_addr),
    .last       (rd_last)
  );

  mover_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_seq (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .advance    (wr_adv),
    .base       (dst),
    .len        (len),
    .descending (descending),
    .addr       (wr_addr),
    .last       (wr_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      wenable <= 1'b0;
      radr    <= '0;
      wadr    <= '0;
      wvalue  <= '0;
      err_q   <= 1'b0;
      fill_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          error   <= 1'b0;
          wenable <= 1'b0;
          if (accept) begin
            fill_q <= fill_value;
            err_q  <= reject;
            if (reject || empty) state <= S_DONE;
            else if (mode == MODE_FILL) state <= S_FILL;
            else state <= S_PRIME;
          end
        end
        S_PRIME: begin
          busy  <= 1'b1;
          radr  <= rd_addr;
          state <= rd_last ? S_DRAIN : S_STREAM;
        end
        // Word k is written from the data read last cycle while word k+1 is read.
        S_STREAM: begin
          wenable <= 1'b1;
          wadr    <= wr_addr;
          wvalue  <= rvalue;
          radr    <= rd_addr;
          if (rd_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          wenable <= 1'b1;
          wadr    <= wr_addr;
          wvalue  <= rvalue;
          state   <= S_DONE;
        end
        S_FILL: begin
          busy    <= 1'b1;
          wenable <= 1'b1;
          wadr    <= wr_addr;
          wvalue  <= fill_q;
          if (wr_last) state <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          wenable <= 1'b0;
          done    <= 1'b1;
          error   <= err_q;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_memory_block_mover.sv
module tb_memory_block_mover;
  import memory_block_mover_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RS = 4096;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW-1:0] len = '0;
  logic [DW-1:0] fill_value = '0;
  logic          busy, done, error, wenable;
  logic [AW-1:0] radr, wadr;
  logic [DW-1:0] rvalue, wvalue;
  state_t        dbg_state;

  always #5 clock = ~clock;

  memory_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_SIZE(RS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .fill_value(fill_value),
    .busy(busy), .done(done), .error(error),
    .radr(radr), .rvalue(rvalue), .wadr(wadr), .wvalue(wvalue),
    .wenable(wenable), .dbg_state(dbg_state)
  );

  // ---------------- RAM attached to the DUT ----------------
  logic [DW-1:0] ram [0:RS-1];
  logic          init_en = 1'b0;
  logic [31:0]   init_salt = '0;
  logic          poke_en = 1'b0;
  logic [11:0]   poke_adr = '0;
  logic [DW-1:0] poke_data = '0;

  function automatic logic [31:0] init_word(input int i, input logic [31:0] salt);
    return (32'(i) * 32'h9E37_79B9) ^ salt;
  endfunction

  assign rvalue = (radr < RS) ? ram[radr[11:0]] : '0;

  always @(negedge clock) begin
    if (init_en) begin
      for (int i = 0; i < RS; i++) ram[i] <= init_word(i, init_salt);
    end else if (poke_en) begin
      ram[poke_adr] <= poke_data;
    end else if (wenable && (wadr < RS)) begin
      ram[wadr[11:0]] <= wvalue;
    end
  end

  // ---------------- model and scoreboard ----------------
  logic [DW-1:0] ref_mem [0:RS-1];
  logic [63:0]   exp_q[$];
  logic [AW-1:0] m_radr = '0;
  logic [AW-1:0] m_wadr = '0;
  logic [DW-1:0] m_wvalue = '0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ram_image(input string name);
    int bad;
    int first_bad;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < RS; i++) begin
      if (ram[i] !== ref_mem[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s words_differing=%0d first_addr=%0d actual=%0h expected=%0h",
               name, bad, first_bad, ram[first_bad], ref_mem[first_bad]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input int adr, input logic [31:0] data);
    poke_adr  = 12'(adr);
    poke_data = data;
    poke_en   = 1'b1;
    @(negedge clock);
    #1 poke_en = 1'b0;
    ref_mem[adr] = data;
  endtask

  // Called at the drive point (#1 after a posedge) while the DUT is idle.
  // Predicts every output for each cycle of the request from the transfer rules
  // and a memmove of the model memory, then checks the DUT cycle by cycle.
  task automatic run_job(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [31:0] l, input logic [31:0] fv, input bit poke_busy,
                         output int done_c, output int first_we_c);
    logic [31:0] tmp [0:15];
    logic [31:0] a;
    logic [31:0] idx;
    logic [63:0] rec;
    bit          is_copy, rej, empty, desc, active;
    bit          e_busy, e_done, e_err, e_we;
    int          n, last_c;

    is_copy = (m == MODE_COPY);
    rej     = (({1'b0, d} + {1'b0, l}) > 33'd4096) ||
              (is_copy && (({1'b0, s} + {1'b0, l}) > 33'd4096));
    empty   = !rej && ((l == 0) || (is_copy && (s == d)));
    active  = !rej && !empty;
    desc    = is_copy && (d > s);
    n       = active ? int'(l) : 0;

    if (active) begin
      for (int k = 0; k < n; k++) begin
        a = s + 32'(k);
        tmp[k] = is_copy ? ref_mem[a[11:0]] : fv;
      end
      for (int k = 0; k < n; k++) begin
        idx = desc ? 32'(n - 1 - k) : 32'(k);
        exp_q.push_back({d + idx, tmp[idx[3:0]]});
      end
      for (int k = 0; k < n; k++) begin
        a = d + 32'(k);
        ref_mem[a[11:0]] = tmp[k];
      end
    end
    last_c = !active ? 1 : (is_copy ? n + 2 : n + 1);

    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_value = fv;
    @(posedge clock);
    #1;
    // Scramble the request fields: only the accepting edge may use them.
    start = 1'b0; mode = 1'($urandom); src = $urandom; dst = $urandom;
    len = $urandom; fill_value = $urandom;

    done_c = 0;
    first_we_c = 0;
    for (int c = 1; c <= last_c + 1; c++) begin
      @(posedge clock);
      #1;
      if (poke_busy && last_c >= 3 && c == 2) begin
        start = 1'b1; mode = 1'($urandom); src = $urandom_range(0, 50);
        dst = $urandom_range(0, 50); len = $urandom_range(1, 5);
      end else begin
        start = 1'b0;
      end
      e_busy = active && (c < last_c);
      e_done = (c == last_c);
      e_err  = e_done && rej;
      e_we   = active && (is_copy ? (c >= 2 && c <= n + 1) : (c <= n));
      if (active && is_copy && c <= n)
        m_radr = s + (desc ? 32'(n - c) : 32'(c - 1));
      if (e_we) begin
        if (exp_q.size() > 0) begin
          rec = exp_q.pop_front();
          m_wadr = rec[63:32];
          m_wvalue = rec[31:0];
        end
      end
      if (done && done_c == 0) done_c = c;
      if (wenable && first_we_c == 0) first_we_c = c;
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("error", error, e_err);
      check("wenable", wenable, e_we);
      check("radr", radr, m_radr);
      check("wadr", wadr, m_wadr);
      check("wvalue", wvalue, m_wvalue);
    end
    check("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    check_ram_image("ram_image");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc, wc;
    logic [31:0] ra, rb, rc, rd, s, d, l;
    int di;

    init_salt = $urandom;
    for (int i = 0; i < RS; i++) ref_mem[i] = init_word(i, init_salt);
    init_en = 1'b1;
    @(negedge clock);
    #1 init_en = 1'b0;

    // Reset state
    @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wenable", wenable, 0);
    check("rst_radr", radr, 0);
    check("rst_wadr", wadr, 0);
    check("rst_wvalue", wvalue, 0);
    check("rst_state", dbg_state, S_IDLE);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Plain copy 16..19 -> 100..103
    ra = 32'hA0A0_0001; rb = 32'hB0B0_0002; rc = 32'hC0C0_0003; rd = 32'hD0D0_0004;
    poke(16, ra); poke(17, rb); poke(18, rc); poke(19, rd);
    @(posedge clock);
    #1;
    run_job(MODE_COPY, 16, 100, 4, 0, 1'b0, dc, wc);
    check("copy_done_cycle", dc, 6);
    check("copy_first_we_cycle", wc, 2);
    check("copy_w100", ram[100], 32'hA0A0_0001);
    check("copy_w101", ram[101], 32'hB0B0_0002);
    check("copy_w102", ram[102], 32'hC0C0_0003);
    check("copy_w103", ram[103], 32'hD0D0_0004);
    check("copy_w99_kept", ram[99], init_word(99, init_salt));
    check("copy_w104_kept", ram[104], init_word(104, init_salt));

    // Overlapping copies, upward then downward
    poke(0, 1); poke(1, 2); poke(2, 3); poke(3, 4);
    @(posedge clock);
    #1;
    run_job(MODE_COPY, 0, 1, 4, 0, 1'b0, dc, wc);
    check("ovl_up_w1", ram[1], 1);
    check("ovl_up_w2", ram[2], 2);
    check("ovl_up_w3", ram[3], 3);
    check("ovl_up_w4", ram[4], 4);
    run_job(MODE_COPY, 1, 0, 4, 0, 1'b0, dc, wc);
    check("ovl_dn_w0", ram[0], 1);
    check("ovl_dn_w1", ram[1], 2);
    check("ovl_dn_w2", ram[2], 3);
    check("ovl_dn_w3", ram[3], 4);

    // Fill
    run_job(MODE_FILL, 0, 200, 3, 32'hDEAD_BEEF, 1'b0, dc, wc);
    check("fill_done_cycle", dc, 4);
    check("fill_w200", ram[200], 32'hDEAD_BEEF);
    check("fill_w202", ram[202], 32'hDEAD_BEEF);
    check("fill_w203_kept", ram[203], init_word(203, init_salt));

    // Rejected, empty, and same-address requests
    run_job(MODE_COPY, 0, 4094, 4, 0, 1'b0, dc, wc);
    check("reject_done_cycle", dc, 1);
    check("reject_no_write", wc, 0);
    run_job(MODE_COPY, 4093, 10, 4, 0, 1'b0, dc, wc);
    check("reject_src_done_cycle", dc, 1);
    run_job(MODE_FILL, 0, 32'hFFFF_FFFF, 2, 7, 1'b0, dc, wc);
    check("reject_wrap_done_cycle", dc, 1);
    run_job(MODE_COPY, 5, 600, 0, 0, 1'b0, dc, wc);
    check("empty_done_cycle", dc, 1);
    run_job(MODE_COPY, 300, 300, 5, 0, 1'b0, dc, wc);
    check("same_done_cycle", dc, 1);
    run_job(MODE_FILL, 0, 4092, 4, 32'h1234_5678, 1'b0, dc, wc);
    check("fill_top_done_cycle", dc, 5);

    // Start pulsed while busy
    run_job(MODE_COPY, 16, 500, 4, 0, 1'b1, dc, wc);
    check("poke_done_cycle", dc, 6);
    check("poke_w500", ram[500], 32'hA0A0_0001);

    // Reset in the middle of a descending copy, after two writes
    start = 1'b1; mode = MODE_COPY; src = 16; dst = 300; len = 4;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_wenable", wenable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_state", dbg_state, S_IDLE);
    @(posedge clock);
    #1 reset_n = 1'b1;
    check("midrst_w303", ram[303], 32'hD0D0_0004);
    check("midrst_w302", ram[302], 32'hC0C0_0003);
    check("midrst_w301_kept", ram[301], init_word(301, init_salt));
    check("midrst_w300_kept", ram[300], init_word(300, init_salt));
    ref_mem[303] = 32'hD0D0_0004;
    ref_mem[302] = 32'hC0C0_0003;
    m_radr = '0; m_wadr = '0; m_wvalue = '0;
    check_ram_image("midrst_ram_image");
    @(posedge clock);
    #1;

    // Randomized requests
    for (int t = 0; t < 40; t++) begin
      l = $urandom_range(0, 12);
      s = $urandom_range(0, RS - 1);
      case ($urandom_range(0, 5))
        0: d = $urandom_range(RS - 16, RS - 1);
        1: s = $urandom_range(RS - 16, RS - 1);
        2, 3: begin
          di = int'(s) + int'($urandom_range(0, 8)) - 4;
          if (di < 0) di = 0;
          d = 32'(di);
        end
        default: d = $urandom_range(0, RS - 1);
      endcase
      run_job(1'($urandom), s, d, l, $urandom, 1'($urandom), dc, wc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
